bcd_scan_ctrl: RTL
==================

Name: bcd_scan_ctrl

Overview:
- Sequencing controller for the 8-bit binary-to-BCD converter (`bcd`) that sits after the combinational multiplier.
- Accepts a product value over a valid/ready handshake and holds it stable on the converter input.
- Time-multiplexes the converter's hundreds/tens/ones digits onto a shared 7-segment bus with optional leading-zero blanking.
- New values change only at frame boundaries, so the display never tears mid-frame.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays enabled; legal range is at least 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  producer has a value on in_binary.
- in_binary  in  8  unsigned value to display (0..255).
- in_ready  out  1  controller can accept a value this cycle.
- bcd_binary  out  8  drives the `bcd` instance's binary input; equals the display register.
- bcd_hundreds  in  4  hundreds digit returned by the `bcd` instance.
- bcd_tens  in  4  tens digit returned by the `bcd` instance.
- bcd_ones  in  4  ones digit returned by the `bcd` instance.
- blank_en  in  1  1 = blank leading zeros.
- digit_en  out  3  one-hot digit strobe: [2]=hundreds, [1]=tens, [0]=ones; active-high.
- seg  out  7  segments {g,f,e,d,c,b,a}; active-high.

Behaviour:
- Registers: disp (8b), pend (8b), pend_v (1b), state {IDLE, SCAN_H, SCAN_T, SCAN_O}, cnt with width max(1, clog2(SCAN_DIV)).
- Reset (rst_n=0 at a clock edge) sets: disp=0, pend=0, pend_v=0, cnt=0, state=IDLE.
- After reset: in_ready=1, bcd_binary=0, digit_en=000, seg=0000000.
- Reset mid-scan: the next edge returns to IDLE and discards both pend and the displayed value.
- in_ready = !pend_v, combinational from the register.
- Accept: in_valid & in_ready at an edge sets pend<=in_binary and pend_v<=1.
- Accept and transfer never share an edge: transfer requires pend_v=1, and pend_v=1 forces in_ready=0.
- bcd_binary = disp at all times; changes only on a transfer edge.
- IDLE:
  - digit_en=000, seg=0.
  - If pend_v=1: disp<=pend, pend_v<=0, cnt<=0, go SCAN_H.
- Latency: value accepted at edge k, transferred at edge k+1, hundreds strobe visible in the cycle after edge k+1.
- SCAN_H / SCAN_T / SCAN_O: digit_en = 100 / 010 / 001 respectively.
- Counter in any scan state:
  - cnt < SCAN_DIV-1: cnt increments.
  - cnt = SCAN_DIV-1: cnt<=0, advance H->T->O->H.
- Leaving SCAN_O (frame end): if pend_v=1, transfer (disp<=pend, pend_v<=0) on that same edge.
- IDLE is never re-entered except by reset.
- SCAN_DIV=1: each digit enabled for exactly one cycle; frame length is 3 cycles.
- seg is combinational from state and the selected bcd_* digit, with no register stage.
- Digit encoding (gfedcba):

  | Digit | seg     |
  |-------|---------|
  | 0     | 0111111 |
  | 1     | 0000110 |
  | 2     | 1011011 |
  | 3     | 1001111 |
  | 4     | 1100110 |
  | 5     | 1101101 |
  | 6     | 1111101 |
  | 7     | 0000111 |
  | 8     | 1111111 |
  | 9     | 1101111 |
  | 10–15 | 1000000 (dash, error indication) |

- Blanking when blank_en=1:
  - SCAN_H: seg=0 if hundreds=0.
  - SCAN_T: seg=0 if hundreds=0 and tens=0.
  - Ones is never blanked.
  - digit_en still strobes during blanked digits.
- blank_en is sampled combinationally and may change at any time.

Test Plan:
- Reset held for 2 edges with in_valid=1 -> in_ready=1 after release; no accept occurs during reset; digit_en=000, seg=0, bcd_binary=0.
- SCAN_DIV=4, send 255 (bcd returns 2,5,5) -> accept at edge k, bcd_binary=255 after k+1, digit_en 100x4, 010x4, 001x4 cycles; seg = 1011011, 1101101, 1101101; the frame repeats.
- blank_en=1, send 7 (0,0,7) -> H and T slots seg=0 with strobes asserted, O slot seg=0000111; send 0 -> O slot seg=0111111.
- Back-pressure: while displaying 255, send 100, then hold in_valid with 42 -> 100 accepted, in_ready=0 until the SCAN_O->SCAN_H edge; bcd_binary switches to 100 on that edge; 42 is accepted the next cycle and displayed one frame later.
- Force bcd_tens=12 during SCAN_T -> seg=1000000.
- Assert rst_n=0 for one edge mid-SCAN_T with pend_v=1 -> IDLE, in_ready=1, pending value lost, outputs all zero.

Source files
------------

// File: rtl/bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_scan_ctrl
//
// Sequencing controller for the 8-bit binary-to-BCD converter. A value is
// taken over a valid/ready handshake into a one-entry pending register. At
// a frame boundary it moves into the display register, which drives the
// converter input. The hundreds/tens/ones digits returned by the converter
// are then time-multiplexed onto a shared 7-segment bus. Leading zeros can
// optionally be blanked.
//
// Parameters:
//   SCAN_DIV      clock cycles each digit stays enabled (>= 1)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   in_valid      producer has a value on in_binary
//   in_binary     value to display (0..255)
//   in_ready      controller can accept a value this cycle
//   bcd_binary    converter input; always equals the display register
//   bcd_hundreds  hundreds digit from the converter
//   bcd_tens      tens digit from the converter
//   bcd_ones      ones digit from the converter
//   blank_en      1 = blank leading zeros
//   digit_en      one-hot strobe: [2]=hundreds, [1]=tens, [0]=ones
//   seg           segments {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module bcd_scan_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_binary,
  output logic       in_ready,
  output logic [7:0] bcd_binary,
  input  logic [3:0] bcd_hundreds,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  input  logic       blank_en,
  output logic [2:0] digit_en,
  output logic [6:0] seg
);

  localparam int CNT_W = (SCAN_DIV <= 1) ? 1 : $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN_H = 2'd1,
    SCAN_T = 2'd2,
    SCAN_O = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       disp_q, disp_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: state registers are updated only with non-blocking assignments, so
  // every always_ff reads pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready   = !pend_v_q;
  assign bcd_binary = disp_q;

  // Next-state logic. Accept and transfer cannot coincide: a transfer needs
  // pend_v_q=1, which holds in_ready low.
  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cnt_d    = cnt_q;

    if (in_valid && in_ready) begin
      pend_d   = in_binary;
      pend_v_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          disp_d   = pend_q;
          pend_v_d = 1'b0;
          cnt_d    = '0;
          state_d  = SCAN_H;
        end
      end
      default: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          unique case (state_q)
            SCAN_H:  state_d = SCAN_T;
            SCAN_T:  state_d = SCAN_O;
            default: begin
              // Frame end: the only point a new value may reach the display.
              state_d = SCAN_H;
              if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    unique case (d)
      4'd0:    seg_encode = 7'b0111111;
      4'd1:    seg_encode = 7'b0000110;
      4'd2:    seg_encode = 7'b1011011;
      4'd3:    seg_encode = 7'b1001111;
      4'd4:    seg_encode = 7'b1100110;
      4'd5:    seg_encode = 7'b1101101;
      4'd6:    seg_encode = 7'b1111101;
      4'd7:    seg_encode = 7'b0000111;
      4'd8:    seg_encode = 7'b1111111;
      4'd9:    seg_encode = 7'b1101111;
      default: seg_encode = 7'b1000000; // dash: converter returned a non-BCD digit
    endcase
  endfunction

  // Output decode: purely combinational so a blank_en change shows at once.
  always_comb begin
    digit_en = 3'b000;
    seg      = 7'b0000000;
    unique case (state_q)
      SCAN_H: begin
        digit_en = 3'b100;
        if (!(blank_en && bcd_hundreds == 4'd0)) seg = seg_encode(bcd_hundreds);
      end
      SCAN_T: begin
        digit_en = 3'b010;
        if (!(blank_en && bcd_hundreds == 4'd0 && bcd_tens == 4'd0))
          seg = seg_encode(bcd_tens);
      end
      SCAN_O: begin
        digit_en = 3'b001;
        seg      = seg_encode(bcd_ones);
      end
      default: ;
    endcase
  end

endmodule
